// File: rtl/seq_match_fsm.sv
// -----------------------------------------------------------------------------
// seq_match_fsm
//
// Mealy serial pattern matcher. It watches a one-bit serial stream and compares
// the most recent W qualified bits against a programmable pattern. Completion is
// flagged combinationally on y in the same cycle as the completing bit. It
// supports overlapping and non-overlapping detection and keeps a saturating
// match counter.
//
// Parameters
//   W      : pattern length in bits (2..16)
//   CNT_W  : match counter width (2..16)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   x          in   serial data bit
//   x_valid    in   x is sampled only when high
//   load       in   capture pattern (and mask) and re-arm; discards coincident x
//   pattern    in   [W-1:0] match target, bit W-1 oldest, bit 0 newest
//   mask       in   [W-1:0] care mask (only when SEQ_MATCH_MASK_EN is defined)
//   overlap    in   1 = overlapping detection, 0 = flush history after a match
//   cnt_clr    in   synchronous clear of match_cnt, wins over a coincident match
//   y          out  [1:0] 00 idle/no bit, 01 bit no match, 10 match,
//                   11 match while match_cnt is saturated
//   match_cnt  out  [CNT_W-1:0] saturating match count
//   armed      out  high whenever a pattern is loaded (state != IDLE)
//
// Optional feature macro: SEQ_MATCH_MASK_EN adds the mask port; bit positions
// whose captured mask bit is 0 are don't-care in the compare.
// -----------------------------------------------------------------------------
module seq_match_fsm #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             load,
    input  logic [W-1:0]     pattern,
`ifdef SEQ_MATCH_MASK_EN
    input  logic [W-1:0]     mask,
`endif
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic [1:0]       y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FW = $clog2(W);
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);
    localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic [W-1:0]     pat_r, pat_nx_s;
    // Only the W-1 newest history bits are stored: the oldest bit of the
    // W-bit window is always shifted out by the next candidate, so it never
    // takes part in a compare.
    logic [W-2:0]     hist_r, hist_nx_s;
    logic [FW-1:0]    fill_r, fill_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [1:0]       y_s;

    logic [W-1:0]     shift_s;
    logic             match_s;
    logic             bit_s;
    logic             cand_s;
    logic             hit_s;
    logic             sat_s;

`ifdef SEQ_MATCH_MASK_EN
    logic [W-1:0]     msk_r, msk_nx_s;
`endif

    assign shift_s = {hist_r, x};

`ifdef SEQ_MATCH_MASK_EN
    assign match_s = (((shift_s ^ pat_r) & msk_r) == {W{1'b0}});
`else
    assign match_s = (shift_s == pat_r);
`endif

    // A bit only counts when qualified, armed, and not swallowed by a load.
    assign bit_s  = x_valid && !load && (state_r != IDLE);
    assign cand_s = bit_s && ((state_r == RUN) ||
                              ((state_r == FILL) && (fill_r == FILL_LAST)));
    assign hit_s  = cand_s && match_s;
    assign sat_s  = (cnt_r == {CNT_W{1'b1}});

    // Next-state, datapath updates and Mealy status output.
    always_comb begin
        state_nx_s = state_r;
        pat_nx_s   = pat_r;
        hist_nx_s  = hist_r;
        fill_nx_s  = fill_r;
        cnt_nx_s   = cnt_r;
        y_s        = 2'b00;
`ifdef SEQ_MATCH_MASK_EN
        msk_nx_s   = msk_r;
`endif

        if (load) begin
            state_nx_s = FILL;
            pat_nx_s   = pattern;
            hist_nx_s  = {(W-1){1'b0}};
            fill_nx_s  = {FW{1'b0}};
`ifdef SEQ_MATCH_MASK_EN
            msk_nx_s   = mask;
`endif
        end else if (bit_s) begin
            hist_nx_s = shift_s[W-2:0];
            if (hit_s) begin
                y_s = sat_s ? 2'b11 : 2'b10;
            end else begin
                y_s = 2'b01;
            end
            case (state_r)
                FILL: begin
                    if (cand_s) begin
                        state_nx_s = RUN;
                    end else begin
                        fill_nx_s = fill_r + FILL_ONE;
                    end
                end
                RUN: begin
                    state_nx_s = RUN;
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
            // Non-overlapping mode starts a fresh window after every match.
            if (hit_s && !overlap) begin
                state_nx_s = FILL;
                hist_nx_s  = {(W-1){1'b0}};
                fill_nx_s  = {FW{1'b0}};
            end else begin
                fill_nx_s = fill_nx_s;
            end
        end else begin
            y_s = 2'b00;
        end

        // Clear beats a coincident match; the count sticks at all-ones.
        if (cnt_clr) begin
            cnt_nx_s = {CNT_W{1'b0}};
        end else if (hit_s && !sat_s) begin
            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            pat_r   <= {W{1'b0}};
            hist_r  <= {(W-1){1'b0}};
            fill_r  <= {FW{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
`ifdef SEQ_MATCH_MASK_EN
            msk_r   <= {W{1'b1}};
`endif
        end else begin
            state_r <= state_nx_s;
            pat_r   <= pat_nx_s;
            hist_r  <= hist_nx_s;
            fill_r  <= fill_nx_s;
            cnt_r   <= cnt_nx_s;
`ifdef SEQ_MATCH_MASK_EN
            msk_r   <= msk_nx_s;
`endif
        end
    end

    assign y         = y_s;
    assign match_cnt = cnt_r;
    assign armed     = (state_r != IDLE);

endmodule

// File: tb/tb_seq_match_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_match_fsm
//
// Directed self-checking bench for seq_match_fsm with W=4 and CNT_W=2.
// Inputs change on the falling edge; y is checked 1 time unit later, and
// registered outputs are checked on a later falling edge.
// Optional macro SEQ_MATCH_MASK_EN enables the mask port and its vectors.
// -----------------------------------------------------------------------------
module tb_seq_match_fsm;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             x;
    logic             x_valid;
    logic             load;
    logic [W-1:0]     pattern;
    logic [W-1:0]     mask;
    logic             overlap;
    logic             cnt_clr;
    logic [1:0]       y;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    int n_vec = 0;
    int n_err = 0;

    seq_match_fsm #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_valid   (x_valid),
        .load      (load),
        .pattern   (pattern),
`ifdef SEQ_MATCH_MASK_EN
        .mask      (mask),
`endif
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .y         (y),
        .match_cnt (match_cnt),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of serial input and check the Mealy output.
    task automatic send(input logic b, input logic v, input logic clr,
                        input logic [1:0] ey, input string tag);
        @(negedge clk);
        x       = b;
        x_valid = v;
        load    = 1'b0;
        cnt_clr = clr;
        #1 check(tag, {30'd0, y}, {30'd0, ey});
    endtask

    // Load a pattern, optionally with a coincident valid bit that must be dropped.
    task automatic do_load(input logic [W-1:0] p, input logic [W-1:0] m,
                           input logic ovl, input logic b, input logic v);
        @(negedge clk);
        load    = 1'b1;
        pattern = p;
        mask    = m;
        overlap = ovl;
        x       = b;
        x_valid = v;
        cnt_clr = 1'b0;
        #1 check("y_on_load", {30'd0, y}, 32'd0);
    endtask

    // Idle one cycle and check registered outputs.
    task automatic idle_check(input logic [CNT_W-1:0] ecnt, input logic earm, input string tag);
        @(negedge clk);
        x_valid = 1'b0;
        load    = 1'b0;
        cnt_clr = 1'b0;
        #1;
        check({tag, "_cnt"}, {{(32-CNT_W){1'b0}}, match_cnt}, {{(32-CNT_W){1'b0}}, ecnt});
        check({tag, "_armed"}, {31'd0, armed}, {31'd0, earm});
    endtask

    initial begin
        rst     = 1'b0;
        x       = 1'b0;
        x_valid = 1'b0;
        load    = 1'b0;
        pattern = 4'b0000;
        mask    = 4'b1111;
        overlap = 1'b1;
        cnt_clr = 1'b0;
        #1;
        check("rst_y", {30'd0, y}, 32'd0);
        check("rst_cnt", {{(32-CNT_W){1'b0}}, match_cnt}, 32'd0);
        check("rst_armed", {31'd0, armed}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Unarmed: valid bits are ignored.
        send(1'b1, 1'b1, 1'b0, 2'b00, "idle_bit");
        idle_check(2'd0, 1'b0, "idle");

        // Overlapping: 1,0,1,1,0,1,1 matches on bits 4 and 7.
        do_load(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 2'b01, "ov_b1");
        send(1'b0, 1'b1, 1'b0, 2'b01, "ov_b2");
        send(1'b1, 1'b1, 1'b0, 2'b01, "ov_b3");
        send(1'b1, 1'b1, 1'b0, 2'b10, "ov_b4");
        send(1'b0, 1'b0, 1'b0, 2'b00, "ov_gap");
        send(1'b0, 1'b1, 1'b0, 2'b01, "ov_b5");
        send(1'b1, 1'b1, 1'b0, 2'b01, "ov_b6");
        send(1'b1, 1'b1, 1'b0, 2'b10, "ov_b7");
        idle_check(2'd2, 1'b1, "ov");

        // Clear, then non-overlapping: only bit 4 matches; history refills.
        send(1'b0, 1'b0, 1'b1, 2'b00, "clr");
        idle_check(2'd0, 1'b1, "clr");
        do_load(4'b1011, 4'b1111, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 2'b01, "no_b1");
        send(1'b0, 1'b1, 1'b0, 2'b01, "no_b2");
        send(1'b1, 1'b1, 1'b0, 2'b01, "no_b3");
        send(1'b1, 1'b1, 1'b0, 2'b10, "no_b4");
        send(1'b0, 1'b1, 1'b0, 2'b01, "no_b5");
        send(1'b1, 1'b1, 1'b0, 2'b01, "no_b6");
        send(1'b1, 1'b1, 1'b0, 2'b01, "no_b7");
        send(1'b1, 1'b1, 1'b0, 2'b01, "no_b8");
        idle_check(2'd1, 1'b1, "no");

        // Load coincident with a bit that would complete 1011: dropped.
        do_load(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 2'b01, "ld_b1");
        send(1'b0, 1'b1, 1'b0, 2'b01, "ld_b2");
        send(1'b1, 1'b1, 1'b0, 2'b01, "ld_b3");
        do_load(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b1);
        idle_check(2'd1, 1'b1, "ld");
        send(1'b1, 1'b1, 1'b0, 2'b01, "ld_n1");
        send(1'b0, 1'b1, 1'b0, 2'b01, "ld_n2");
        send(1'b1, 1'b1, 1'b0, 2'b01, "ld_n3");
        send(1'b1, 1'b1, 1'b0, 2'b10, "ld_n4");
        idle_check(2'd2, 1'b1, "ld_after");

        // Saturation with CNT_W=2 on an all-ones stream.
        send(1'b0, 1'b0, 1'b1, 2'b00, "sat_clr");
        do_load(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 2'b01, "sat_b1");
        send(1'b1, 1'b1, 1'b0, 2'b01, "sat_b2");
        send(1'b1, 1'b1, 1'b0, 2'b01, "sat_b3");
        send(1'b1, 1'b1, 1'b0, 2'b10, "sat_m1");
        send(1'b1, 1'b1, 1'b0, 2'b10, "sat_m2");
        send(1'b1, 1'b1, 1'b0, 2'b10, "sat_m3");
        send(1'b1, 1'b1, 1'b0, 2'b11, "sat_m4");
        send(1'b1, 1'b1, 1'b0, 2'b11, "sat_m5");
        idle_check(2'd3, 1'b1, "sat");
        send(1'b1, 1'b1, 1'b1, 2'b11, "sat_clr_match");
        idle_check(2'd0, 1'b1, "sat_clr");
        send(1'b1, 1'b1, 1'b0, 2'b10, "sat_after");
        idle_check(2'd1, 1'b1, "sat_after");

        // Asynchronous reset mid-FILL.
        do_load(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 2'b01, "ar_b1");
        send(1'b0, 1'b1, 1'b0, 2'b01, "ar_b2");
        @(posedge clk);
        #2;
        x       = 1'b1;
        x_valid = 1'b1;
        rst     = 1'b0;
        #1;
        check("ar_armed", {31'd0, armed}, 32'd0);
        check("ar_cnt", {{(32-CNT_W){1'b0}}, match_cnt}, 32'd0);
        check("ar_y", {30'd0, y}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send(1'b1, 1'b1, 1'b0, 2'b00, "ar_i1");
        send(1'b0, 1'b1, 1'b0, 2'b00, "ar_i2");
        send(1'b1, 1'b1, 1'b0, 2'b00, "ar_i3");
        send(1'b1, 1'b1, 1'b0, 2'b00, "ar_i4");
        idle_check(2'd0, 1'b0, "ar");

`ifdef SEQ_MATCH_MASK_EN
        // Masked compare: middle bits are don't-care.
        do_load(4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 2'b01, "mk_a1");
        send(1'b0, 1'b1, 1'b0, 2'b01, "mk_a2");
        send(1'b0, 1'b1, 1'b0, 2'b01, "mk_a3");
        send(1'b1, 1'b1, 1'b0, 2'b10, "mk_a4");
        send(1'b1, 1'b1, 1'b0, 2'b01, "mk_b1");
        send(1'b1, 1'b1, 1'b0, 2'b01, "mk_b2");
        send(1'b1, 1'b1, 1'b0, 2'b01, "mk_b3");
        send(1'b1, 1'b1, 1'b0, 2'b10, "mk_b4");
        send(1'b1, 1'b1, 1'b0, 2'b01, "mk_c1");
        send(1'b1, 1'b1, 1'b0, 2'b01, "mk_c2");
        send(1'b1, 1'b1, 1'b0, 2'b01, "mk_c3");
        send(1'b0, 1'b1, 1'b0, 2'b01, "mk_c4");
        idle_check(2'd2, 1'b1, "mk");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
